booth_mult: RTL and testbench

BOOTH_MULT -- requirements
Module: booth_mult

---
 rtl/booth_mult.sv | 99 +++++++++
 tb/tb_booth_mult.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/booth_mult.sv
// Sequential radix-2 Booth multiplier: 32x32 signed, one iteration per clock.
// The low product word is registered at completion, and a flag reports when the full product needs more than 32 bits.
module booth_mult (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic        ctrl_MULT,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e      state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic [31:0] mcand_q, mcand_d;
  logic [65:0] product_q, product_d;
  logic [31:0] result_q, result_d;
  logic        exc_q, exc_d;

  // 33-bit accumulator so that negating 0x80000000 cannot overflow.
  logic [32:0] mcand_ext;
  logic [32:0] acc_sum;
  logic [65:0] step;

  assign mcand_ext = {mcand_q[31], mcand_q};

  always_comb begin
    acc_sum = product_q[65:33];
    unique case (product_q[1:0])
      2'b01:   acc_sum = product_q[65:33] + mcand_ext;
      2'b10:   acc_sum = product_q[65:33] + ~mcand_ext + 33'd1;
      default: acc_sum = product_q[65:33];
    endcase
    step = {acc_sum[32], acc_sum, product_q[32:1]};
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    mcand_d   = mcand_q;
    product_d = product_q;
    result_d  = result_q;
    exc_d     = exc_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (ctrl_MULT) begin
          mcand_d   = data_operandA;
          product_d = {33'b0, data_operandB, 1'b0};
          count_d   = 5'd0;
          state_d   = RUN;
        end else begin
          state_d   = IDLE;
        end
      end
      RUN: begin
        product_d = step;
        if (count_q == 5'd31) begin
          state_d  = DONE;
          result_d = step[32:1];
          exc_d    = (step[64:33] != {32{step[32]}});
        end else begin
          count_d  = count_q + 5'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: reset is synchronous, so it is tested inside the clocked block and not in the sensitivity list.
  // NOTE: sequential state uses non-blocking assignments, so every register samples the pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= IDLE;
      count_q   <= 5'd0;
      mcand_q   <= 32'd0;
      product_q <= 66'd0;
      result_q  <= 32'd0;
      exc_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      mcand_q   <= mcand_d;
      product_q <= product_d;
      result_q  <= result_d;
      exc_q     <= exc_d;
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = (state_q == DONE);
  assign busy           = (state_q == RUN);

endmodule

// File: tb/tb_booth_mult.sv
// Self-checking bench for booth_mult: directed spec vectors plus random operands checked against a signed-arithmetic model.
module tb_booth_mult;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        ctrl_MULT;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  booth_mult dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: full-precision signed product, truncated; overflow when outside int32 range.
  task automatic model(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic e);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    r = p[31:0];
    e = (p > 64'sd2147483647) || (p < -64'sd2147483648);
  endtask

  task automatic start(input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = 1'b1;
    @(negedge clock);
    ctrl_MULT     = 1'b0;
  endtask

  // Called in the cycle after the start edge. Operands are scrambled every cycle while running;
  // a stray start strobe is raised at cycle 'disturb' (negative = never).
  task automatic wait_done(input string tag, input logic [31:0] exp_r, input logic exp_e,
                           input int disturb, input bit b2b,
                           input logic [31:0] b2b_a, input logic [31:0] b2b_b);
    int cyc;
    int busy_cnt;
    cyc = 0;
    busy_cnt = 0;
    while (data_resultRDY !== 1'b1 && cyc < 40) begin
      if (busy === 1'b1) busy_cnt++;
      data_operandA = $urandom;
      data_operandB = $urandom;
      ctrl_MULT     = (cyc == disturb);
      @(negedge clock);
      cyc++;
    end
    ctrl_MULT = 1'b0;
    check({tag, "/latency"}, 64'(cyc), 64'd32);
    check({tag, "/busy_cycles"}, 64'(busy_cnt), 64'd32);
    check({tag, "/result"}, 64'(data_result), 64'(exp_r));
    check({tag, "/exception"}, 64'(data_exception), 64'(exp_e));
    if (b2b) begin
      data_operandA = b2b_a;
      data_operandB = b2b_b;
      ctrl_MULT     = 1'b1;
      @(negedge clock);
      ctrl_MULT     = 1'b0;
      check({tag, "/b2b_rdy_low"}, 64'(data_resultRDY), 64'd0);
      check({tag, "/b2b_busy"}, 64'(busy), 64'd1);
    end else begin
      @(negedge clock);
      check({tag, "/rdy_single"}, 64'(data_resultRDY), 64'd0);
      check({tag, "/result_hold"}, 64'(data_result), 64'(exp_r));
      check({tag, "/exception_hold"}, 64'(data_exception), 64'(exp_e));
    end
  endtask

  initial begin
    logic [31:0] ra, rb, er;
    logic        ee;
    int          rdy_seen;

    reset         = 1'b0;
    ctrl_MULT     = 1'b0;
    data_operandA = 32'd0;
    data_operandB = 32'd0;
    repeat (3) @(negedge clock);
    check("reset/result", 64'(data_result), 64'd0);
    check("reset/exception", 64'(data_exception), 64'd0);
    check("reset/rdy", 64'(data_resultRDY), 64'd0);
    check("reset/busy", 64'(busy), 64'd0);

    // Start in the very first cycle after reset releases, then chain a second op from DONE.
    data_operandA = 32'd3;
    data_operandB = 32'd5;
    ctrl_MULT     = 1'b1;
    reset         = 1'b1;
    @(negedge clock);
    ctrl_MULT     = 1'b0;
    wait_done("3x5", 32'h0000000F, 1'b0, -1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done("m1xm1", 32'h00000001, 1'b0, -1, 1'b0, 32'd0, 32'd0);

    start(32'hFFFFFFF9, 32'd6);
    wait_done("m7x6", 32'hFFFFFFD6, 1'b0, -1, 1'b0, 32'd0, 32'd0);
    start(32'h80000000, 32'd1);
    wait_done("min_x1", 32'h80000000, 1'b0, -1, 1'b0, 32'd0, 32'd0);
    start(32'h80000000, 32'hFFFFFFFF);
    wait_done("min_xm1", 32'h80000000, 1'b1, -1, 1'b0, 32'd0, 32'd0);
    start(32'h00010000, 32'h00010000);
    wait_done("2p16sq", 32'h00000000, 1'b1, -1, 1'b0, 32'd0, 32'd0);

    start(32'd2, 32'd3);
    wait_done("ignore_start", 32'h00000006, 1'b0, 10, 1'b0, 32'd0, 32'd0);

    // Abort mid-run: no completion pulse may ever appear, and all outputs clear.
    start(32'h12345678, 32'h9ABCDEF0);
    repeat (19) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    check("abort/result", 64'(data_result), 64'd0);
    check("abort/exception", 64'(data_exception), 64'd0);
    check("abort/rdy", 64'(data_resultRDY), 64'd0);
    check("abort/busy", 64'(busy), 64'd0);
    rdy_seen = 0;
    repeat (40) begin
      @(negedge clock);
      if (data_resultRDY === 1'b1) rdy_seen++;
    end
    check("abort/no_rdy", 64'(rdy_seen), 64'd0);
    start(32'd4, 32'd4);
    wait_done("4x4", 32'h00000010, 1'b0, -1, 1'b0, 32'd0, 32'd0);

    for (int i = 0; i < 12; i++) begin
      ra = $urandom;
      rb = (i % 3 == 0) ? 32'($signed(16'($urandom))) : $urandom;
      model(ra, rb, er, ee);
      start(ra, rb);
      wait_done($sformatf("rand%0d", i), er, ee, -1, 1'b0, 32'd0, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
